// File: rtl/gf8_pkg.sv
// GF(2^3) arithmetic shared by the syndrome calculator: field polynomial,
// power table of alpha, constant multiplier and the symbol / FSM types.
// Latency: n/a (types and combinational functions). Backpressure: n/a.
package gf8_pkg;

  // x^3 + x + 1
  localparam logic [3:0] GF_POLY = 4'b1011;

  typedef logic [2:0] gf_sym_t;

  // alpha^0 .. alpha^6 (alpha^7 wraps back to alpha^0)
  localparam gf_sym_t GF_ALPHA_POW [0:6] = '{
    3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b111, 3'b101
  };

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Shift-and-add multiply; whenever the shifted operand would overflow into
  // x^3 it is folded back with the low bits of the field polynomial.
  function automatic gf_sym_t gf8_mul(input gf_sym_t a, input gf_sym_t b);
    gf_sym_t p;
    gf_sym_t aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 3; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[1:0], 1'b0} ^ (aa[2] ? GF_POLY[2:0] : 3'b000);
    end
    return p;
  endfunction

endpackage

// File: rtl/gf8_syndrome_calc_if.sv
// Symbol-in / syndromes-out handshake bundle for gf8_syndrome_calc.
// Latency: n/a (wiring only). Backpressure: valid/ready on both sides.
// Ports: in_valid/in_ready/in_data (symbols), out_valid/out_ready/syndromes/err_flag (result).
interface gf8_syndrome_calc_if #(
  parameter int NSYN = 4
);
  import gf8_pkg::*;

  logic              in_valid;
  logic              in_ready;
  gf_sym_t           in_data;
  logic              out_valid;
  logic              out_ready;
  logic [3*NSYN-1:0] syndromes;
  logic              err_flag;

  // Upstream/downstream environment side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, syndromes, err_flag
  );

  // Syndrome calculator side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, syndromes, err_flag
  );

endinterface

// File: rtl/gf8_horner_cell.sv
// One Horner accumulator: S <= S*alpha^POW ^ sym, or S <= sym on the first symbol.
// Latency: result registered on the accepting edge. Backpressure: advances only when i_en.
// Ports: clk, rst_n, i_sym, i_load_first, i_en; o_syn (register), o_next (value it would load).
module gf8_horner_cell
  import gf8_pkg::*;
#(
  parameter int POW = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  gf_sym_t i_sym,
  input  logic    i_load_first,
  input  logic    i_en,
  output gf_sym_t o_syn,
  output gf_sym_t o_next
);

  localparam gf_sym_t C_ALPHA = GF_ALPHA_POW[POW % 7];

  gf_sym_t r_syn;
  gf_sym_t w_mul;
  gf_sym_t w_next;

  assign w_mul  = gf8_mul(r_syn, C_ALPHA);
  // First symbol overwrites, which also discards the previous codeword.
  assign w_next = i_load_first ? i_sym : (w_mul ^ i_sym);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_syn <= '0;
    end else if (i_en) begin
      r_syn <= w_next;
    end
  end

  assign o_syn  = r_syn;
  assign o_next = w_next;

endmodule

// File: rtl/gf8_syndrome_calc.sv
// Streaming RS syndrome calculator over GF(8): S_j = r(alpha^j), j = 1..NSYN, via Horner.
// Latency: out_valid rises on the edge that accepts the Nth symbol; min N+1 cycles/codeword.
// Backpressure: results held (in_ready low) until out_ready; in_valid low stalls accumulation.
// Ports: clk, rst_n (async active-low); bus (slave): in_valid/in_ready/in_data,
//        out_valid/out_ready/syndromes {S_NSYN..S_1}/err_flag.
module gf8_syndrome_calc
  import gf8_pkg::*;
#(
  parameter int N    = 7,
  parameter int NSYN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gf8_syndrome_calc_if.slave   bus
);

  if (N < 2 || N > 7) begin : g_bad_n
    $error("gf8_syndrome_calc: N must be in 2..7");
  end
  if (NSYN < 1 || NSYN > 6) begin : g_bad_nsyn
    $error("gf8_syndrome_calc: NSYN must be in 1..6");
  end

  localparam logic [2:0] C_LAST = 3'(N - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [2:0]             r_cnt;
  logic                   r_err;
  logic                   w_in_ready;
  logic                   w_out_valid;
  logic                   w_acc;
  logic                   w_last;
  logic                   w_first;
  logic [NSYN-1:0][2:0]   w_syn;
  logic [NSYN-1:0][2:0]   w_next;

  assign w_in_ready  = (r_state == ST_ACCUM);
  assign w_out_valid = (r_state == ST_HOLD);
  assign w_acc       = bus.in_valid && w_in_ready;
  assign w_first     = (r_cnt == 3'd0);
  assign w_last      = w_acc && (r_cnt == C_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCUM: if (w_last)        w_state_nxt = ST_HOLD;
      ST_HOLD:  if (bus.out_ready) w_state_nxt = ST_ACCUM;
      default:                     w_state_nxt = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_acc) begin
      r_cnt <= w_last ? 3'd0 : (r_cnt + 3'd1);
    end
  end

  // Flag is taken from the values being loaded so it is valid together with out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_last) begin
      r_err <= |w_next;
    end else if (w_out_valid && bus.out_ready) begin
      r_err <= 1'b0;
    end
  end

  for (genvar j = 1; j <= NSYN; j++) begin : g_cell
    gf8_horner_cell #(
      .POW (j)
    ) u_cell (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_sym        (bus.in_data),
      .i_load_first (w_first),
      .i_en         (w_acc),
      .o_syn        (w_syn[j-1]),
      .o_next       (w_next[j-1])
    );
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.syndromes = w_syn;
  assign bus.err_flag  = r_err;

endmodule

// File: doc/gf8_syndrome_calc.md
Name: gf8_syndrome_calc

Overview:
- Streaming Reed-Solomon syndrome calculator over GF(2^3), primitive polynomial x^3+x+1 (alpha = 3'b010).
- Accepts one 3-bit received symbol per handshake, highest-degree symbol first.
- Evaluates the received polynomial at alpha^1..alpha^NSYN using Horner's rule. Each step is one GF multiply-by-constant plus one GF add (XOR).
- Sits directly upstream of the error-locator/correction stage. Presents the packed syndromes and an error flag through a valid/ready output.

Parameters:
- N, 7, codeword length in symbols; legal range 2..7.
- NSYN, 4, number of syndromes (2t); legal range 1..6.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a symbol.
- in_data  input  3  received symbol r_i; the first accepted symbol is r_(N-1).
- out_valid  output  1  syndromes valid, held until accepted.
- out_ready  input  1  downstream accepts the syndromes.
- syndromes  output  3*NSYN  packed {S_NSYN,...,S_2,S_1}; S_1 occupies bits [2:0].
- err_flag  output  1  1 when any syndrome is non-zero.

Behaviour:
- Reset: rst_n low asynchronously clears all state.
  - State = ACCUM, symbol count = 0.
  - syndromes = 0, err_flag = 0, out_valid = 0.
  - in_ready = 1 (in_ready is decoded from state).
- States:
  - ACCUM: in_ready = 1, out_valid = 0.
  - HOLD: in_ready = 0, out_valid = 1.
- Accept: an input symbol is accepted when in_valid && in_ready. No other cycle changes the accumulators.
- On accept with count == 0: every S_j <= in_data. This discards the previous codeword's values.
- On accept with count > 0: every S_j <= gfmul(S_j, alpha^j) XOR in_data, for all j in parallel.
- Count increments on every accept.
- When the accept carries count == N-1:
  - count <= 0, state <= HOLD.
  - err_flag <= OR-reduction of the next-state syndromes.
  - Latency: out_valid rises on the clock edge that accepts the Nth symbol.
- In HOLD:
  - syndromes and err_flag hold stable and in_data is ignored.
  - On out_valid && out_ready, state <= ACCUM.
  - The next codeword's first symbol can be accepted one cycle later.
- Throughput: minimum N+1 cycles per codeword.
- Syndrome values in ACCUM after a codeword:
  - syndromes keep their last value until the next first-symbol accept. Only out_valid qualifies them.
  - err_flag clears to 0 on the HOLD->ACCUM transition.
- Arithmetic:
  - gfmul is polynomial multiplication mod x^3+x+1, purely combinational, 3-bit result.
  - Addition is bitwise XOR.
  - No width growth anywhere.
- Power table for the constants alpha^j: a1=010, a2=100, a3=011, a4=110, a5=111, a6=101, a7=001.
- in_valid low mid-codeword: a stall. State, count and accumulators hold.
- Reset mid-codeword: the partial codeword is lost. The next accepted symbol is treated as r_(N-1) of a new codeword.
- Parameter checks: out-of-range N or NSYN is an elaboration error.

Decomposition:
- Shared package gf8_pkg:
  - GF_POLY = 4'b1011.
  - GF_ALPHA_POW, a constant array of alpha^0..alpha^6.
  - Function gf8_mul(a,b) returning 3 bits.
  - Type alias for a 3-bit GF symbol.
- One sub-module: gf8_horner_cell.
  - Holds one syndrome register.
  - Parameter POW selects its constant alpha^POW.
  - Inputs: sym, load_first, en.
  - Instantiated NSYN times in a generate loop.
- The count/FSM stays in the top module.

Test Plan:
- Valid codeword: stream g(x) coefficients 000,000,001,011,001,010,011 back-to-back -> out_valid rises on the edge accepting the 7th symbol; syndromes = 12'h000; err_flag = 0.
- Error at position 0: six 000 symbols then 001 -> syndromes = 12'h249 (all S_j = 001); err_flag = 1.
- Error at position 1: symbols 000 x5, 001, 000 -> syndromes = 12'hCE2 (S1=010, S2=100, S3=011, S4=110); err_flag = 1.
- Backpressure: hold out_ready = 0 for 3 cycles after a codeword while in_valid = 1 -> in_ready = 0 and syndromes stable for all 3 cycles. Raise out_ready -> one handshake, then in_ready = 1 the next cycle. The following all-zero codeword yields 12'h000 with no residue from the previous codeword.
- Stall and reset: insert in_valid = 0 gaps between symbols of the position-1 case -> same 12'hCE2. Separately, assert rst_n low after 3 symbols -> all outputs 0 immediately; a subsequent valid codeword yields 12'h000.
